pulse_meter: RTL
================

Name: pulse_meter

Overview:
- Receive-side counterpart to the timer block: it measures a periodic pulse train instead of generating one.
- Synchronises an external pulse signal and measures, in clk cycles, its high time and its rising-edge-to-rising-edge period.
- Emits one-cycle result strobes with saturating-counter overflow and stall reporting.
- Sits on the I/O side of the design, directly downstream of a timer output or an external pin.

Parameters:
- CNT_W, 16: width of the cycle counter and of both measurement outputs. Legal range 4..32.
- SYNC_STAGES, 2: number of synchroniser flops on sig_in. Legal range 2..4.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion is synchronous to clk.
- en  input  1  measurement enable; 0 forces IDLE.
- sig_in  input  1  asynchronous pulse input.
- period  output  CNT_W  last measured period in clk cycles.
- width  output  CNT_W  last measured high time in clk cycles.
- result  output  1  one-cycle strobe: period/width/ovf just updated.
- ovf  output  1  counter saturated during the measurement just reported.
- stalled  output  1  counter currently saturated; no edge within 2^CNT_W-1 cycles.

Behaviour:
- Reset (rst=0, async): period=0, width=0, result=0, ovf=0, stalled=0, cnt=0, hi_cnt=0, all sync flops=0, state=IDLE.
- Synchroniser: SYNC_STAGES flops, plus one history flop.
  - rise = sync_out & ~hist; fall = ~sync_out & hist.
  - Latency is identical for both edges, so measured values are exact cycle counts.
- Input-to-strobe latency: result rises SYNC_STAGES+2 clk edges after the sig_in rising edge that closes a period.
- Counter: cnt, CNT_W bits.
  - Set to 1 on every rise event.
  - Otherwise increments by 1 each cycle in HIGH/LOW, saturating at 2^CNT_W-1.
  - sat flag set when cnt reaches max; cleared on rise event.
- FSM:
  - IDLE: cnt held 0. If en=1 and rise -> HIGH, cnt<=1, sat<=0. A fall in IDLE is ignored; the initial level never produces a measurement.
  - HIGH: on fall -> hi_cnt<=cnt, hi_sat<=sat, -> LOW.
  - LOW: on rise -> period<=cnt, width<=hi_cnt, ovf<=sat|hi_sat, result<=1 for one cycle, cnt<=1, sat<=0, -> HIGH.
  - en=0 in any state -> IDLE next cycle, cnt<=0, no result. period/width/ovf hold their last values.
- Example: high 3 cycles, low 5 cycles -> width=3, period=8.
- Saturation:
  - If cnt saturates, the reported period = 2^CNT_W-1 and ovf=1.
  - If HIGH saturated, width = 2^CNT_W-1 and ovf=1.
- stalled = sat while in HIGH or LOW; 0 in IDLE. It is combinationally derived from registered state, i.e. glitch-free.
- result is asserted at most once per period. The minimum measurable pulse is 1 cycle high and 1 cycle low (period=2); shorter pulses are not resolved.
- Simultaneous events: en falling in the same cycle as a closing rise -> en wins, no result.
- Reset mid-measurement clears everything. The first rise after reset only arms, same as IDLE.
- period/width/ovf are stable between result strobes.

Test Plan:
- Reset with sig_in=1 held, then release; en=1; sig_in 10 high/10 low -> no result before the second rise; then result each 20 cycles with period=20, width=10, ovf=0.
- Duty sweep: high 1 / low 1, then high 7 / low 2 -> period=2, width=1; then period=9, width=7; one result per period, none missed.
- Overflow with CNT_W=4: high 3, low 20 -> period=15, width=3, ovf=1. stalled=1 from the cycle cnt hits 15 until the closing rise, then 0.
- Enable gating: drop en mid-LOW for 4 cycles, then restore -> no result for the interrupted period; next valid period reported correctly after one arming rise.
- Async reset mid-HIGH: assert rst=0 for 3 ns, asynchronous to clk -> all outputs 0 immediately; measurement restarts from IDLE.
- Loopback: timer.result drives sig_in -> measured period/width equal the timer's programmed interval, stable across 10 consecutive results.

Source files
------------

// File: rtl/pulse_meter.sv
// pulse_meter: measures the high time and the rising-edge-to-rising-edge
// period of an asynchronous pulse train in clk cycles. Results are reported
// with a one-cycle strobe, a saturation (overflow) flag and a live stall flag.
module pulse_meter #(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] width,
   output logic             result,
   output logic             ovf,
   output logic             stalled
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   sync_out;
   logic                   rise_q;
   logic                   fall_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   sat_q;
   logic [CNT_W-1:0]       hi_cnt_q;
   logic                   hi_sat_q;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   sat_inc;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Synchroniser chain plus history flop; edge events are registered so that
   // rising and falling edges reach the FSM with the same fixed latency.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         hist_q <= sync_out;
         rise_q <= sync_out & ~hist_q;
         fall_q <= ~sync_out & hist_q;
      end
   end

   // Saturating increment of the cycle counter and the matching sat flag.
   always_comb begin
      cnt_inc = cnt_q;
      sat_inc = sat_q;
      if (cnt_q != CNT_MAX) begin
         cnt_inc = cnt_q + CNT_ONE;
      end
      sat_inc = (cnt_inc == CNT_MAX);
   end

   // Measurement FSM: arms on a rise, captures high time on the fall and
   // reports period/width/ovf on the next rise. en=0 overrides everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sat_q    <= 1'b0;
         hi_cnt_q <= '0;
         hi_sat_q <= 1'b0;
         period   <= '0;
         width    <= '0;
         ovf      <= 1'b0;
         result   <= 1'b0;
      end else begin
         result <= 1'b0;
         if (!en) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  cnt_q <= '0;
                  sat_q <= 1'b0;
                  if (rise_q) begin
                     state_q <= HIGH;
                     cnt_q   <= CNT_ONE;
                  end
               end
               HIGH: begin
                  cnt_q <= cnt_inc;
                  sat_q <= sat_inc;
                  if (fall_q) begin
                     hi_cnt_q <= cnt_q;
                     hi_sat_q <= sat_q;
                     state_q  <= LOW;
                  end
               end
               LOW: begin
                  if (rise_q) begin
                     period  <= cnt_q;
                     width   <= hi_cnt_q;
                     ovf     <= sat_q | hi_sat_q;
                     result  <= 1'b1;
                     cnt_q   <= CNT_ONE;
                     sat_q   <= 1'b0;
                     state_q <= HIGH;
                  end else begin
                     cnt_q <= cnt_inc;
                     sat_q <= sat_inc;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  sat_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   // Stall indication comes only from registered state, so it cannot glitch.
   always_comb begin
      stalled = sat_q & (state_q != IDLE);
   end

endmodule
